key_sched_192_ctrl: RTL and testbench



---
 rtl/aes_pkg.sv | 43 ++++
 rtl/key_sched_192_ctrl_if.sv | 30 +++
 rtl/key_step_192.sv | 23 ++
 rtl/key_sched_192_ctrl.sv | 123 ++++++++++++
 tb/tb_key_sched_192_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule FSM states, RCON table and S-box lookup.
// Used by the AES-192 key schedule and the SubBytes datapath.
package aes_pkg;

   localparam int NK192     = 6;
   localparam int NR192     = 12;
   localparam int NWORDS192 = 52;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_EXPAND,
      ST_DONE
   } state_t;

   localparam logic [0:7][7:0] RCON = {
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80
   };

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

endpackage

// File: rtl/key_sched_192_ctrl_if.sv
// Handshake and read-port bundle of the AES-192 key schedule.
// Build with KEY_SCHED_ZEROIZE_EN to add the zeroize request line.
interface key_sched_192_ctrl_if;
   logic         start;
   logic [191:0] key_in;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic [3:0]   rk_idx;
   logic [127:0] rk_out;
`ifdef KEY_SCHED_ZEROIZE_EN
   logic         zeroize;
`endif

   modport master (
`ifdef KEY_SCHED_ZEROIZE_EN
      output zeroize,
`endif
      output start, key_in, rk_idx,
      input  busy, done, keys_valid, rk_out
   );

   modport slave (
`ifdef KEY_SCHED_ZEROIZE_EN
      input  zeroize,
`endif
      input  start, key_in, rk_idx,
      output busy, done, keys_valid, rk_out
   );
endinterface

// File: rtl/key_step_192.sv
// One AES-192 expansion step: six words in, the next six words out.
// w_in[0] is the oldest word of the step (w[6i]).
module key_step_192
   import aes_pkg::*;
(
   input  logic [NK192-1:0][31:0] w_in,
   input  logic [31:0]            rcon,
   output logic [NK192-1:0][31:0] w_out
);

   logic [31:0] rot;
   logic [31:0] sub;

   assign rot = {w_in[NK192-1][23:0], w_in[NK192-1][31:24]};
   assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

   // Each new word chains off the one just produced.
   always_comb begin
      w_out[0] = w_in[0] ^ sub ^ rcon;
      for (int k = 1; k < NK192; k++) w_out[k] = w_out[k-1] ^ w_in[k];
   end

endmodule

// File: rtl/key_sched_192_ctrl.sv
// AES-192 key schedule sequencer: loads a key, expands 52 words in 8 steps, serves round keys.
// Optional KEY_SCHED_ZEROIZE_EN adds a zeroize input that wipes the schedule and returns to IDLE.
module key_sched_192_ctrl
   import aes_pkg::*;
#(
   parameter int NUM_ROUNDKEYS = NR192 + 1,
   parameter int NUM_ITER      = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   key_sched_192_ctrl_if.slave ks
);

   localparam int ITW = $clog2(NUM_ITER);

   state_t                  state_q, state_d;
   logic [ITW-1:0]          iter_q;
   logic [31:0]             w_q [NWORDS192];
   logic                    done_q, kv_q;
   logic [127:0]            rk_q, rk_sel;
   logic                    ld_en, exp_en, fin, zero_req;
   logic [NK192-1:0][31:0]  step_in, step_out;

`ifdef KEY_SCHED_ZEROIZE_EN
   assign zero_req = ks.zeroize;
`else
   assign zero_req = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // The key is captured on the accepting edge, so w0..w5 are in place during LOAD.
   always_comb begin
      state_d = state_q;
      ld_en   = 1'b0;
      exp_en  = 1'b0;
      fin     = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: if (ks.start) begin
            state_d = ST_LOAD;
            ld_en   = 1'b1;
         end
         ST_LOAD: state_d = ST_EXPAND;
         ST_EXPAND: begin
            exp_en = 1'b1;
            if (iter_q == ITW'(NUM_ITER - 1)) begin
               state_d = ST_DONE;
               fin     = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (zero_req) begin
         state_d = ST_IDLE;
         ld_en   = 1'b0;
         exp_en  = 1'b0;
         fin     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         iter_q <= '0;
         done_q <= 1'b0;
         kv_q   <= 1'b0;
      end else begin
         done_q <= fin;
         if (ld_en || zero_req) iter_q <= '0;
         else if (exp_en)       iter_q <= iter_q + 1'b1;
         if (ld_en || zero_req) kv_q <= 1'b0;
         else if (fin)          kv_q <= 1'b1;
      end
   end

   always_comb begin
      step_in = '0;
      for (int i = 0; i < NUM_ITER; i++)
         if (iter_q == ITW'(i))
            for (int k = 0; k < NK192; k++) step_in[k] = w_q[NK192*i + k];
   end

   key_step_192 u_step (
      .w_in  (step_in),
      .rcon  ({RCON[iter_q], 24'h0}),
      .w_out (step_out)
   );

   // Step i lands in words 6i+6..6i+11; words past 51 simply have no slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int j = 0; j < NWORDS192; j++) w_q[j] <= '0;
      end else if (zero_req) begin
         for (int j = 0; j < NWORDS192; j++) w_q[j] <= '0;
      end else begin
         for (int k = 0; k < NK192; k++)
            if (ld_en) w_q[k] <= ks.key_in[32*(NK192-1-k) +: 32];
         for (int j = NK192; j < NWORDS192; j++)
            if (exp_en && iter_q == ITW'(j/NK192 - 1)) w_q[j] <= step_out[j % NK192];
      end
   end

   always_comb begin
      rk_sel = '0;
      for (int r = 0; r < NUM_ROUNDKEYS; r++)
         if (ks.rk_idx == 4'(r))
            rk_sel = {w_q[4*r], w_q[4*r+1], w_q[4*r+2], w_q[4*r+3]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               rk_q <= '0;
      else if (zero_req || !kv_q) rk_q <= '0;
      else                      rk_q <= rk_sel;
   end

   assign ks.busy       = (state_q == ST_LOAD) || (state_q == ST_EXPAND);
   assign ks.done       = done_q;
   assign ks.keys_valid = kv_q;
   assign ks.rk_out     = rk_q;

endmodule

// File: tb/tb_key_sched_192_ctrl.sv
// Randomized bench for key_sched_192_ctrl against a FIPS-197 style key expansion model.
// The model derives its S-box from GF(2^8) inversion plus the affine map.
module tb_key_sched_192_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   key_sched_192_ctrl_if ks();

   key_sched_192_ctrl dut (.clk(clk), .rst_n(rst_n), .ks(ks));

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   logic [7:0]  sb [256];
   logic [31:0] mw [52];
   bit          mvalid = 1'b0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a = a_in, b = b_in, p = 8'h0;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] d = {b, b};
      return d[15-n -: 8];
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv = 8'h0;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subrot(input logic [31:0] t);
      logic [31:0] r = {t[23:0], t[31:24]};
      return {sb[r[31:24]], sb[r[23:16]], sb[r[15:8]], sb[r[7:0]]};
   endfunction

   task automatic model_expand(input logic [191:0] key);
      logic [7:0]  rc = 8'h01;
      logic [31:0] t;
      for (int k = 0; k < 6; k++) mw[k] = key[32*(5-k) +: 32];
      for (int i = 6; i < 52; i++) begin
         t = mw[i-1];
         if (i % 6 == 0) begin
            t  = subrot(t) ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         mw[i] = mw[i-6] ^ t;
      end
   endtask

   function automatic logic [127:0] exp_rk(input int idx);
      if (!mvalid || idx > 12) return '0;
      return {mw[4*idx], mw[4*idx+1], mw[4*idx+2], mw[4*idx+3]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int idx, input string tag);
      ks.rk_idx = 4'(idx);
      tick();
      chk(tag, ks.rk_out, exp_rk(idx));
   endtask

   function automatic logic [191:0] rnd_key();
      return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
   endfunction

   // extra=1 re-pulses start (with a junk key) at cycles 3 and 6 of the run.
   task automatic run(input logic [191:0] key, input bit extra);
      int lat = -1;
      ks.key_in = key;
      ks.start  = 1'b1;
      mvalid    = 1'b0;
      model_expand(key);
      for (int c = 1; c <= 20; c++) begin
         tick();
         ks.start = extra && (c == 3 || c == 6);
         if (extra) ks.key_in = rnd_key();
         if (c == 1) begin
            chk("load_busy", 128'(ks.busy), 128'd1);
            chk("load_kv", 128'(ks.keys_valid), 128'd0);
         end
         if (ks.done) begin
            lat = c;
            break;
         end
      end
      ks.start = 1'b0;
      chk("done_lat", 128'(lat), 128'd10);
      chk("kv_done", 128'(ks.keys_valid), 128'd1);
      mvalid = 1'b1;
      tick();
      chk("done_pulse", 128'(ks.done), 128'd0);
   endtask

   logic [191:0] fips_key;

   initial begin
      ks.start  = 1'b0;
      ks.key_in = '0;
      ks.rk_idx = '0;
`ifdef KEY_SCHED_ZEROIZE_EN
      ks.zeroize = 1'b0;
`endif
      build_sbox();
      #12;
      chk("rst_busy", 128'(ks.busy), 128'd0);
      chk("rst_done", 128'(ks.done), 128'd0);
      chk("rst_kv", 128'(ks.keys_valid), 128'd0);
      chk("rst_rk", ks.rk_out, 128'd0);
      rst_n = 1'b1;
      tick();
      rd(1, "pre_done_rd1");
      rd(12, "pre_done_rd12");

      fips_key = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
      run(fips_key, 1'b0);
      ks.rk_idx = 4'd1;
      tick();
      chk("fips_rk1", ks.rk_out, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
      ks.rk_idx = 4'd12;
      tick();
      chk("fips_rk12", ks.rk_out, 128'he98ba06f448c773c8ecc720401002202);
      rd(13, "oob_rd13");
      rd(15, "oob_rd15");
      for (int i = 0; i < 13; i++) rd(i, "fips_sweep");

      run(fips_key, 1'b1);
      for (int i = 0; i < 13; i++) rd(i, "restart_ign_sweep");

      run('0, 1'b0);
      ks.rk_idx = 4'd1;
      tick();
      chk("zero_key_rk1", ks.rk_out, 128'h00000000000000006263636362636363);

      // Reset asserted mid-expansion must clear outputs without a clock edge.
      ks.key_in = rnd_key();
      ks.start  = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         tick();
         ks.start = 1'b0;
      end
      #2 rst_n = 1'b0;
      #1;
      mvalid = 1'b0;
      chk("arst_busy", 128'(ks.busy), 128'd0);
      chk("arst_kv", 128'(ks.keys_valid), 128'd0);
      chk("arst_rk", ks.rk_out, 128'd0);
      tick();
      rst_n = 1'b1;
      rd(1, "post_rst_rd");
      run(rnd_key(), 1'b0);
      for (int i = 0; i < 13; i++) rd(i, "post_rst_sweep");

      for (int n = 0; n < 4; n++) begin
         run(rnd_key(), n[0]);
         for (int c = 0; c < 30; c++) rd($urandom_range(0, 15), "rand_rd");
      end

`ifdef KEY_SCHED_ZEROIZE_EN
      ks.zeroize = 1'b1;
      ks.start   = 1'b1;
      ks.key_in  = rnd_key();
      tick();
      ks.zeroize = 1'b0;
      ks.start   = 1'b0;
      mvalid     = 1'b0;
      chk("zz_kv", 128'(ks.keys_valid), 128'd0);
      chk("zz_busy", 128'(ks.busy), 128'd0);
      for (int i = 0; i < 16; i++) begin
         rd(i, "zz_rd");
         chk("zz_no_done", 128'(ks.done), 128'd0);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
